chien_search: RTL
=================

CHIEN_SEARCH -- requirements
Module: chien_search

Interface
REQ-001 Parameter: T, 8, maximum locator degree; T+1 coefficient registers, 1 <= T <= 16.
REQ-002 Parameter: N, 8191, number of code positions searched, 1 <= N <= 8191.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 Port: lam_in  in  13  locator coefficient, GF(2^13) polynomial basis, bit 0 = x^0 term.
REQ-006 Port: lam_valid  in  1  lam_in valid this cycle.
REQ-007 Port: lam_start  in  1  marks coefficient lambda_0; qualified by lam_valid.
REQ-008 Port: deg_in  in  5  locator degree from the final Euclidean cell; sampled with lambda_0.
REQ-009 Port: busy  out  1  high in LOAD and SEARCH.
REQ-010 Port: pos_valid  out  1  err_pos/err_flag valid.
REQ-011 Port: err_pos  out  13  code position p under test.
REQ-012 Port: err_flag  out  1  Lambda(alpha^-p) == 0.
REQ-013 Port: err_cnt  out  5  roots found so far, saturating at 31.
REQ-014 Port: done  out  1  one-cycle pulse, search complete.
REQ-015 Port: fail  out  1  valid with done; err_cnt != latched degree.

Function
REQ-016 Field GF(2^13), primitive polynomial x^13+x^4+x^3+x+1, alpha = x; all arithmetic XOR/constant multiply, no carries.
REQ-017 FSM states IDLE, LOAD, SEARCH, DONE; IDLE->LOAD on lam_start&lam_valid; LOAD->SEARCH after coefficient T accepted; SEARCH->DONE after last position; DONE->IDLE unconditionally.
REQ-018 Coefficients lambda_0..lambda_T arrive in ascending order, one per lam_valid cycle; lam_valid low in LOAD stalls without loss.
REQ-019 lam_start&lam_valid during LOAD restarts loading: that beat is stored as lambda_0, deg_in re-latched.
REQ-020 lam_start/lam_valid ignored in SEARCH and DONE.
REQ-021 Register j initialised to lambda_j; each SEARCH cycle register j <= register j * alpha^(8191-j) (constant multiplier).
REQ-022 Search cycle k (0..N-1) tests p = k: sum = XOR of all T+1 registers; root when sum == 0.
REQ-023 Outputs registered: position k reported (pos_valid=1, err_pos=k, err_flag) after edge E+1+k, E = edge accepting lambda_T.
REQ-024 err_cnt cleared when lambda_0 accepted, incremented on each err_flag, saturates at 31, held after done until next lambda_0.
REQ-025 done and fail asserted after edge E+1+N (one cycle after last position), pos_valid low that cycle.
REQ-026 fail = (err_cnt != latched deg_in) OR (latched deg_in > T); held with err_cnt.
REQ-027 All-zero locator: every position flags; err_cnt saturates; fail = 1.

Reset
REQ-028 reset low: state IDLE; busy, pos_valid, err_pos, err_flag, err_cnt, done, fail all 0; coefficient registers 0.
REQ-029 Reset mid-LOAD or mid-SEARCH aborts with no done pulse; first lambda_0 after release starts a clean load.

Configuration
REQ-030 Macro CHIEN_EARLY_STOP_EN defined: when err_cnt reaches latched degree (degree >= 1), search ends; done asserted the cycle after that root's report, fail = 0, remaining positions not reported.
REQ-031 CHIEN_EARLY_STOP_EN defined, latched degree 0: SEARCH skipped, done one cycle after lambda_T accepted, err_cnt 0, fail 0.
REQ-032 CHIEN_EARLY_STOP_EN undefined: all N positions always searched per REQ-023/025.

Verification (bench parameters T=8, N=64)
REQ-033 Lambda=1, deg 0 -> 64 pos_valid cycles, no err_flag, done with err_cnt=0, fail=0.
REQ-034 Lambda=1+alpha^5 x, deg 1 -> err_flag only at err_pos=5; done err_cnt=1, fail=0; with CHIEN_EARLY_STOP_EN done directly after p=5.
REQ-035 Lambda=1+(alpha^3+alpha^10)x+alpha^13 x^2, deg 2 -> flags at p=3 and p=10 only, err_cnt=2, fail=0.
REQ-036 Lambda=1+alpha^5 x, deg_in=2 -> err_cnt=1, fail=1 (both builds).
REQ-037 lam_valid gaps of 3 cycles after lambda_2, then lam_start re-asserted mid-LOAD -> second locator only evaluated, results per REQ-034.
REQ-038 reset asserted at p=20 -> all outputs 0 asynchronously, no done; reload of REQ-035 locator yields REQ-035 result.

Source files
------------

// File: rtl/chien_search_if.sv
// Locator-load and search-result signals of the Chien search block.
interface chien_search_if;
    logic [12:0] lam_in;
    logic        lam_valid;
    logic        lam_start;
    logic [4:0]  deg_in;
    logic        busy;
    logic        pos_valid;
    logic [12:0] err_pos;
    logic        err_flag;
    logic [4:0]  err_cnt;
    logic        done;
    logic        fail;

    modport master (
        output lam_in, lam_valid, lam_start, deg_in,
        input  busy, pos_valid, err_pos, err_flag, err_cnt, done, fail
    );

    modport slave (
        input  lam_in, lam_valid, lam_start, deg_in,
        output busy, pos_valid, err_pos, err_flag, err_cnt, done, fail
    );
endinterface

// File: rtl/chien_search.sv
// Chien search over GF(2^13): evaluates Lambda(alpha^-p) for p = 0..N-1 and flags roots.
// Optional macro CHIEN_EARLY_STOP_EN ends the search once the root count reaches the latched degree.
module chien_search #(
    parameter int T = 8,
    parameter int N = 8191
) (
    input  logic           clk,
    input  logic           reset,
    chien_search_if.slave  bus
);
    localparam logic [4:0]  T_L    = 5'(T);
    localparam logic [12:0] LAST_K = 13'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SEARCH = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Multiply by alpha^-1: alpha^-1 = alpha^12 + alpha^3 + alpha^2 + 1.
    function automatic logic [12:0] gf_mul_ainv(input logic [12:0] x);
        return {1'b0, x[12:1]} ^ (x[0] ? 13'h100D : 13'h0000);
    endfunction

    // Multiply by alpha^(8191-j) as j cascaded alpha^-1 steps (constant network per j).
    function automatic logic [12:0] gf_mul_ainv_pow(input logic [12:0] x, input int j);
        logic [12:0] y;
        y = x;
        for (int i = 0; i < 16; i++) begin
            if (i < j) begin
                y = gf_mul_ainv(y);
            end else begin
                y = y;
            end
        end
        return y;
    endfunction

    state_t      state_q, state_d;
    logic [12:0] lam_q [0:T];
    logic [12:0] lam_d [0:T];
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  deg_q, deg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [12:0] k_q, k_d;
    logic [12:0] err_pos_q, err_pos_d;
    logic        busy_q, busy_d;
    logic        pos_valid_q, pos_valid_d;
    logic        err_flag_q, err_flag_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic [12:0] sum_s;
    logic        root_s;
    logic        first_beat_s;
    logic        skip_search_s;
    logic        stop_s;

    // Locator value at the current position: XOR of all rotating coefficient registers.
    always_comb begin
        sum_s = 13'h0000;
        for (int j = 0; j <= T; j++) begin
            sum_s = sum_s ^ lam_q[j];
        end
    end

    assign root_s       = (sum_s == 13'h0000);
    assign first_beat_s = bus.lam_valid & bus.lam_start;

`ifdef CHIEN_EARLY_STOP_EN
    assign skip_search_s = (deg_q == 5'd0);
    assign stop_s        = root_s && (deg_q != 5'd0) &&
                           (({1'b0, cnt_q} + 6'd1) == {1'b0, deg_q});
`else
    assign skip_search_s = 1'b0;
    assign stop_s        = 1'b0;
`endif

    // Next-state, coefficient load/rotation and registered result computation.
    always_comb begin
        state_d     = state_q;
        lam_d       = lam_q;
        idx_d       = idx_q;
        k_d         = k_q;
        deg_d       = deg_q;
        cnt_d       = cnt_q;
        fail_d      = fail_q;
        pos_valid_d = 1'b0;
        err_pos_d   = err_pos_q;
        err_flag_d  = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (first_beat_s) begin
                    lam_d[0] = bus.lam_in;
                    idx_d    = 5'd1;
                    deg_d    = bus.deg_in;
                    cnt_d    = 5'd0;
                    fail_d   = 1'b0;
                    state_d  = S_LOAD;
                end else if ((state_q == S_LOAD) && bus.lam_valid) begin
                    for (int j = 1; j <= T; j++) begin
                        if (idx_q == 5'(j)) begin
                            lam_d[j] = bus.lam_in;
                        end else begin
                            lam_d[j] = lam_q[j];
                        end
                    end
                    if (idx_q == T_L) begin
                        k_d     = 13'd0;
                        state_d = skip_search_s ? S_DONE : S_SEARCH;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_SEARCH: begin
                for (int j = 0; j <= T; j++) begin
                    lam_d[j] = gf_mul_ainv_pow(lam_q[j], j);
                end
                pos_valid_d = 1'b1;
                err_pos_d   = k_q;
                err_flag_d  = root_s;
                if (root_s && (cnt_q != 5'd31)) begin
                    cnt_d = cnt_q + 5'd1;
                end else begin
                    cnt_d = cnt_q;
                end
                if ((k_q == LAST_K) || stop_s) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + 13'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                fail_d  = (cnt_q != deg_q) || (deg_q > T_L);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_LOAD) || (state_d == S_SEARCH);
    end

    // State and output registers; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            for (int j = 0; j <= T; j++) begin
                lam_q[j] <= 13'h0000;
            end
            idx_q       <= 5'd0;
            deg_q       <= 5'd0;
            cnt_q       <= 5'd0;
            k_q         <= 13'd0;
            err_pos_q   <= 13'd0;
            busy_q      <= 1'b0;
            pos_valid_q <= 1'b0;
            err_flag_q  <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lam_q       <= lam_d;
            idx_q       <= idx_d;
            deg_q       <= deg_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            err_pos_q   <= err_pos_d;
            busy_q      <= busy_d;
            pos_valid_q <= pos_valid_d;
            err_flag_q  <= err_flag_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.pos_valid = pos_valid_q;
    assign bus.err_pos   = err_pos_q;
    assign bus.err_flag  = err_flag_q;
    assign bus.err_cnt   = cnt_q;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
endmodule
